// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/mem/write-back sequencer for the
// 16-bit datapath, with memory handshake, stall hold, HALT opcode and a
// bus-timeout error that parks the machine in HALT.
//
// Handshake: memReq is a request level held high for every FETCH/MEM cycle;
// a cycle with memReq=1 and memReady=1 completes the transfer and the FSM
// advances on that clock edge. memReq is never withdrawn by the controller
// until the transfer completes, times out, or reset is asserted.
module multicycle_ctrl #(
  parameter int INSTR_W = 16,
  parameter int OPC_MSB = 15,
  parameter int OPC_LSB = 12,
  parameter logic [OPC_MSB-OPC_LSB:0] JUMP_OPC  = 4'b0100,
  parameter logic [OPC_MSB-OPC_LSB:0] LOAD_OPC  = 4'b1000,
  parameter logic [OPC_MSB-OPC_LSB:0] STORE_OPC = 4'b1001,
  parameter logic [OPC_MSB-OPC_LSB:0] HALT_OPC  = 4'b1111,
  parameter int WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               memReady,
  input  logic               stall,
  output logic               pcEn,
  output logic               pcIncOrSet,
  output logic               irEn,
  output logic               memReq,
  output logic               memWrite,
  output logic               regWrite,
  output logic               halted,
  output logic               busErr,
  output logic [2:0]         state
);

  localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
  // A zero-width counter is not legal, so a disabled timeout keeps one bit.
  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               bus_err_q, bus_err_d;

  logic [OPC_W-1:0]   opcode;
  logic               is_jump, is_load, is_store, is_halt;
  logic               in_bus_state;
  logic               timeout_hit;

  // Raw (pre-reset-gating) strobes from the state decoder.
  logic pc_en_raw, pc_sel_raw, ir_en_raw, mem_req_raw, mem_wr_raw;
  logic reg_wr_raw, halted_raw;

  // Only the opcode field is decoded; the rest of the word belongs to the datapath.
  logic instr_unused;
  assign instr_unused = ^instruction;

  assign opcode   = instruction[OPC_MSB:OPC_LSB];
  assign is_jump  = (opcode == JUMP_OPC);
  assign is_load  = (opcode == LOAD_OPC);
  assign is_store = (opcode == STORE_OPC);
  assign is_halt  = (opcode == HALT_OPC);

  assign in_bus_state = (state_q == S_FETCH) || (state_q == S_MEM);

  // Timeout fires on the last allowed wait cycle; a late memReady in that
  // same cycle still completes the transfer normally.
  assign timeout_hit = (WAIT_MAX != 0) && in_bus_state && !memReady &&
                       (wait_q == CNT_W'(WAIT_MAX - 1));

  // Next-state and raw strobe decode; stall freezes the non-bus states.
  always_comb begin
    state_d     = state_q;
    bus_err_d   = bus_err_q;
    pc_en_raw   = 1'b0;
    pc_sel_raw  = 1'b0;
    ir_en_raw   = 1'b0;
    mem_req_raw = 1'b0;
    mem_wr_raw  = 1'b0;
    reg_wr_raw  = 1'b0;
    halted_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        if (timeout_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else if (memReady) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          ir_en_raw = 1'b1;
          state_d   = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!stall) begin
          if (is_halt) begin
            state_d = S_HALT;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_MEM: begin
        mem_req_raw = 1'b1;
        mem_wr_raw  = is_store;
        if (timeout_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else if (memReady) begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (!stall) begin
          pc_en_raw  = 1'b1;
          pc_sel_raw = is_jump;
          reg_wr_raw = !(is_store || is_jump);
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        halted_raw = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Wait counter: restarts on any state change, counts unanswered bus cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_bus_state && !memReady) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // State, wait counter and sticky error register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Reset gating: every output reads zero while reset is held low.
  always_comb begin
    pcEn       = reset & pc_en_raw;
    pcIncOrSet = reset & pc_sel_raw;
    irEn       = reset & ir_en_raw;
    memReq     = reset & mem_req_raw;
    memWrite   = reset & mem_wr_raw;
    regWrite   = reset & reg_wr_raw;
    halted     = reset & halted_raw;
    busErr     = reset & bus_err_q;
    state      = reset ? state_q : 3'd0;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. dut_a uses WAIT_MAX=4 for the timeout
// scenarios; dut_b keeps the default WAIT_MAX=15 and shares every input.
module tb_multicycle_ctrl;

  // Flag bit positions: {pcEn,pcIncOrSet,irEn,memReq,memWrite,regWrite,halted,busErr}
  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] PCEN = 8'h80;
  localparam logic [7:0] PCIS = 8'h40;
  localparam logic [7:0] IREN = 8'h20;
  localparam logic [7:0] MREQ = 8'h10;
  localparam logic [7:0] MWR  = 8'h08;
  localparam logic [7:0] RW   = 8'h04;
  localparam logic [7:0] HLT  = 8'h02;
  localparam logic [7:0] BE   = 8'h01;

  // ---------------- clock / reset / inputs ----------------
  logic        clock;
  logic        reset;
  logic [15:0] instruction;
  logic        memReady;
  logic        stall;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic       pcEn_a, pcIs_a, irEn_a, memReq_a, memWr_a, regWr_a, halted_a, busErr_a;
  logic [2:0] state_a;
  logic       pcEn_b, pcIs_b, irEn_b, memReq_b, memWr_b, regWr_b, halted_b, busErr_b;
  logic [2:0] state_b;

  multicycle_ctrl #(.WAIT_MAX(4)) dut_a (
    .clock(clock), .reset(reset), .instruction(instruction),
    .memReady(memReady), .stall(stall),
    .pcEn(pcEn_a), .pcIncOrSet(pcIs_a), .irEn(irEn_a), .memReq(memReq_a),
    .memWrite(memWr_a), .regWrite(regWr_a), .halted(halted_a),
    .busErr(busErr_a), .state(state_a)
  );

  multicycle_ctrl dut_b (
    .clock(clock), .reset(reset), .instruction(instruction),
    .memReady(memReady), .stall(stall),
    .pcEn(pcEn_b), .pcIncOrSet(pcIs_b), .irEn(irEn_b), .memReq(memReq_b),
    .memWrite(memWr_b), .regWrite(regWr_b), .halted(halted_b),
    .busErr(busErr_b), .state(state_b)
  );

  logic [10:0] obs_a, obs_b;
  assign obs_a = {state_a, pcEn_a, pcIs_a, irEn_a, memReq_a, memWr_a, regWr_a, halted_a, busErr_a};
  assign obs_b = {state_b, pcEn_b, pcIs_b, irEn_b, memReq_b, memWr_b, regWr_b, halted_b, busErr_b};

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [10:0] o(input logic [2:0] st, input logic [7:0] f);
    return {st, f};
  endfunction

  // ---------------- driver / checker tasks ----------------
  // One clock cycle: sample both DUTs on the falling edge, then move to
  // just after the next rising edge where the caller drives new inputs.
  task automatic cyc_ab(input string tag, input logic [10:0] ea, input logic [10:0] eb);
    @(negedge clock);
    n_cmp++;
    assert (obs_a === ea) else begin
      n_fail++;
      $error("FAIL %s dut_a observed=%h expected=%h", tag, obs_a, ea);
    end
    n_cmp++;
    assert (obs_b === eb) else begin
      n_fail++;
      $error("FAIL %s dut_b observed=%h expected=%h", tag, obs_b, eb);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [10:0] e);
    cyc_ab(tag, e, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    memReady    = 1'b0;
    stall       = 1'b0;

    // Reset held across an edge: everything zero.
    cyc("reset_hold", o(3'd0, NONE));
    reset = 1'b1;

    // ALU op, memReady tied high.
    memReady = 1'b1; instruction = 16'h1234;
    cyc("alu_fetch",  o(3'd0, MREQ));
    cyc("alu_decode", o(3'd1, IREN));
    cyc("alu_exec",   o(3'd2, NONE));
    cyc("alu_wb",     o(3'd4, PCEN | RW));

    // Jump: PC load, no register write.
    instruction = 16'h4ABC;
    cyc("jmp_fetch",  o(3'd0, MREQ));
    cyc("jmp_decode", o(3'd1, IREN));
    cyc("jmp_exec",   o(3'd2, NONE));
    cyc("jmp_wb",     o(3'd4, PCEN | PCIS));

    // Store: five cycles, MEM with write qualifier, no register write.
    instruction = 16'h9000;
    cyc("st_fetch",  o(3'd0, MREQ));
    cyc("st_decode", o(3'd1, IREN));
    cyc("st_exec",   o(3'd2, NONE));
    cyc("st_mem",    o(3'd3, MREQ | MWR));
    cyc("st_wb",     o(3'd4, PCEN));

    // Load with memReady answered on the 4th MEM cycle (last allowed for WAIT_MAX=4).
    instruction = 16'h8001;
    cyc("ld_fetch",  o(3'd0, MREQ));
    cyc("ld_decode", o(3'd1, IREN));
    memReady = 1'b0;
    cyc("ld_exec",   o(3'd2, NONE));
    cyc("ld_mem0",   o(3'd3, MREQ));
    cyc("ld_mem1",   o(3'd3, MREQ));
    cyc("ld_mem2",   o(3'd3, MREQ));
    memReady = 1'b1;
    cyc("ld_mem3",   o(3'd3, MREQ));
    cyc("ld_wb",     o(3'd4, PCEN | RW));

    // Timeout: memReady stuck low from reset.
    reset = 1'b0; memReady = 1'b0;
    cyc("to_reset", o(3'd0, NONE));
    reset = 1'b1;
    cyc("to_fetch0", o(3'd0, MREQ));
    cyc("to_fetch1", o(3'd0, MREQ));
    cyc("to_fetch2", o(3'd0, MREQ));
    cyc("to_fetch3", o(3'd0, MREQ));
    cyc_ab("to_halt",      o(3'd5, HLT | BE), o(3'd0, MREQ));
    cyc_ab("to_halt_hold", o(3'd5, HLT | BE), o(3'd0, MREQ));

    // Reset out of HALT clears busErr; memReady arrives on the 4th fetch cycle.
    reset = 1'b0;
    cyc("halt_reset", o(3'd0, NONE));
    reset = 1'b1; instruction = 16'h1234;
    cyc("late_fetch0", o(3'd0, MREQ));
    cyc("late_fetch1", o(3'd0, MREQ));
    cyc("late_fetch2", o(3'd0, MREQ));
    memReady = 1'b1;
    cyc("late_fetch3", o(3'd0, MREQ));
    cyc("late_decode", o(3'd1, IREN));
    cyc("late_exec",   o(3'd2, NONE));
    cyc("late_wb",     o(3'd4, PCEN | RW));

    // Stall: ignored in FETCH, holds DECODE/EXECUTE/WRITEBACK with strobes off.
    memReady = 1'b0; stall = 1'b1;
    cyc("stl_fetch0", o(3'd0, MREQ));
    memReady = 1'b1;
    cyc("stl_fetch1", o(3'd0, MREQ));
    cyc("stl_decode_hold", o(3'd1, NONE));
    stall = 1'b0;
    cyc("stl_decode", o(3'd1, IREN));
    stall = 1'b1;
    cyc("stl_exec_hold0", o(3'd2, NONE));
    cyc("stl_exec_hold1", o(3'd2, NONE));
    stall = 1'b0;
    cyc("stl_exec", o(3'd2, NONE));
    stall = 1'b1;
    cyc("stl_wb_hold", o(3'd4, NONE));
    stall = 1'b0;
    cyc("stl_wb", o(3'd4, PCEN | RW));

    // HALT opcode: reached three cycles after fetch start, held until reset.
    instruction = 16'hF000;
    cyc("hlt_fetch",  o(3'd0, MREQ));
    cyc("hlt_decode", o(3'd1, IREN));
    cyc("hlt_exec",   o(3'd2, NONE));
    cyc("hlt_state0", o(3'd5, HLT));
    cyc("hlt_state1", o(3'd5, HLT));
    reset = 1'b0;
    cyc("hlt_reset", o(3'd0, NONE));

    // Reset in the middle of a MEM transaction drops memReq immediately.
    reset = 1'b1; instruction = 16'h8001;
    cyc("mr_fetch",  o(3'd0, MREQ));
    cyc("mr_decode", o(3'd1, IREN));
    memReady = 1'b0;
    cyc("mr_exec",   o(3'd2, NONE));
    cyc("mr_mem",    o(3'd3, MREQ));
    reset = 1'b0;
    cyc("mr_reset",  o(3'd0, NONE));
    reset = 1'b1; memReady = 1'b1;
    cyc("mr_refetch", o(3'd0, MREQ));
    cyc("mr_decode2", o(3'd1, IREN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
